// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory geometry, opcodes, HALT word, loader states.
// INST_LOADER_CSUM_EN adds the checksum state to the loader state enum.
package cpu_pkg;

  localparam int INST_W = 20;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_HALT = 2'd3
  } op_e;

  // HALT opcode in the top two bits, every operand field zero
  localparam logic [INST_W-1:0] HALT_WORD = {OP_HALT, 18'h0};

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RB0,
    ST_RB1,
    ST_RB2,
    ST_WRITE,
    ST_FILL,
`ifdef INST_LOADER_CSUM_EN
    ST_CSUM,
`endif
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } ld_state_e;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: collects B0/B1/B2 into one big-endian 20-bit instruction.
// B0 contributes only its low nibble; a non-zero high nibble is flagged.
module byte_packer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_en,
  input  logic [1:0]        byte_pos,
  input  logic [7:0]        byte_in,
  output logic              word_valid,
  output logic [INST_W-1:0] word,
  output logic              nibble_err
);

  logic [3:0] hi_q;
  logic [7:0] b1_q;
  logic [7:0] b2_q;
  logic       vld_q;

  assign nibble_err = byte_en && (byte_pos == 2'd0) && (byte_in[7:4] != 4'h0);
  assign word       = {hi_q, b1_q, b2_q};
  assign word_valid = vld_q;

  // Capture each byte into its slot; pulse valid the cycle after B2 lands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q  <= '0;
      b1_q  <= '0;
      b2_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= byte_en && (byte_pos == 2'd2);
      if (byte_en) begin
        case (byte_pos)
          2'd0:    hi_q <= byte_in[3:0];
          2'd1:    b1_q <= byte_in;
          default: b2_q <= byte_in;
        endcase
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// inst_loader: streams bytes into instruction memory, appends HALT, then
// releases the CPU into run mode and waits for it to halt.
// INST_LOADER_CSUM_EN: expect a trailing XOR checksum byte before FILL.
module inst_loader #(
  parameter int DEPTH  = cpu_pkg::DEPTH,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              inst_wr_en,
  output logic [ADDR_W-1:0] inst_wr_addr,
  output logic [INST_W-1:0] inst_wr_data,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  cpu_pkg::ld_state_e state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [INST_W-1:0]  data_q;
`ifdef INST_LOADER_CSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  logic               in_rb, xfer, fill_wr;
  logic [1:0]         pk_pos;
  logic               pk_vld, pk_nerr;
  logic [19:0]        pk_word;
  logic [ADDR_W-1:0]  cur_addr;
  logic [INST_W-1:0]  cur_data;

  assign in_rb = (state_q == cpu_pkg::ST_RB0) || (state_q == cpu_pkg::ST_RB1) ||
                 (state_q == cpu_pkg::ST_RB2);
`ifdef INST_LOADER_CSUM_EN
  assign byte_ready = in_rb || (state_q == cpu_pkg::ST_CSUM);
`else
  assign byte_ready = in_rb;
`endif
  assign xfer   = byte_valid && byte_ready;
  assign pk_pos = (state_q == cpu_pkg::ST_RB0) ? 2'd0 :
                  (state_q == cpu_pkg::ST_RB1) ? 2'd1 : 2'd2;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (xfer && in_rb),
    .byte_pos   (pk_pos),
    .byte_in    (byte_in),
    .word_valid (pk_vld),
    .word       (pk_word),
    .nibble_err (pk_nerr)
  );

  // Write port: live values while strobing, held registers otherwise
  assign fill_wr    = (state_q == cpu_pkg::ST_FILL) && (len_q < DEPTH_L);
  assign inst_wr_en = ((state_q == cpu_pkg::ST_WRITE) && pk_vld) || fill_wr;
  assign cur_addr   = (state_q == cpu_pkg::ST_FILL) ? len_q[ADDR_W-1:0] : cnt_q[ADDR_W-1:0];
  assign cur_data   = (state_q == cpu_pkg::ST_FILL) ? INST_W'(cpu_pkg::HALT_WORD) : INST_W'(pk_word);
  assign inst_wr_addr = inst_wr_en ? cur_addr : addr_q;
  assign inst_wr_data = inst_wr_en ? cur_data : data_q;

  assign cpu_run = (state_q == cpu_pkg::ST_RUN) || (state_q == cpu_pkg::ST_DONE);
  assign done    = (state_q == cpu_pkg::ST_DONE);
  assign error   = (state_q == cpu_pkg::ST_ERROR);
  assign busy    = !((state_q == cpu_pkg::ST_IDLE) || done || error);
  assign cnt_inc = cnt_q + 1'b1;

  // Next-state, counter, length latch and checksum accumulation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
`ifdef INST_LOADER_CSUM_EN
    csum_d  = csum_q;
    if (xfer && in_rb) csum_d = csum_q ^ byte_in;
`endif
    case (state_q)
      cpu_pkg::ST_IDLE, cpu_pkg::ST_DONE, cpu_pkg::ST_ERROR: begin
        if (start) begin
          if (prog_len == '0 || prog_len > DEPTH_L) begin
            state_d = cpu_pkg::ST_ERROR;
          end else begin
            len_d   = prog_len;
            cnt_d   = '0;
`ifdef INST_LOADER_CSUM_EN
            csum_d  = '0;
`endif
            state_d = cpu_pkg::ST_RB0;
          end
        end
      end
      cpu_pkg::ST_RB0: if (xfer) state_d = pk_nerr ? cpu_pkg::ST_ERROR : cpu_pkg::ST_RB1;
      cpu_pkg::ST_RB1: if (xfer) state_d = cpu_pkg::ST_RB2;
      cpu_pkg::ST_RB2: if (xfer) state_d = cpu_pkg::ST_WRITE;
      cpu_pkg::ST_WRITE: begin
        cnt_d = cnt_inc;
        if (cnt_inc < len_q) state_d = cpu_pkg::ST_RB0;
`ifdef INST_LOADER_CSUM_EN
        else                 state_d = cpu_pkg::ST_CSUM;
`else
        else                 state_d = cpu_pkg::ST_FILL;
`endif
      end
`ifdef INST_LOADER_CSUM_EN
      cpu_pkg::ST_CSUM: if (xfer) state_d = (byte_in == csum_q) ? cpu_pkg::ST_FILL : cpu_pkg::ST_ERROR;
`endif
      cpu_pkg::ST_FILL: state_d = cpu_pkg::ST_RUN;
      cpu_pkg::ST_RUN:  if (cpu_halted) state_d = cpu_pkg::ST_DONE;
      default:          state_d = cpu_pkg::ST_IDLE;
    endcase
  end

  // State, counters and write-port hold registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= cpu_pkg::ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef INST_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
`ifdef INST_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
      if (inst_wr_en) begin
        addr_q <= cur_addr;
        data_q <= cur_data;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Scoreboard bench for inst_loader: expected writes are queued as bytes are
// driven and popped whenever the DUT strobes instruction memory.
module tb_inst_loader;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          inst_wr_en;
  logic [AW-1:0] inst_wr_addr;
  logic [19:0]   inst_wr_data;
  logic          cpu_run;
  logic          cpu_halted = 1'b0;
  logic          busy, done, error;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [19:0]   d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  inst_loader dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .inst_wr_en(inst_wr_en), .inst_wr_addr(inst_wr_addr), .inst_wr_data(inst_wr_data),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write
  always @(negedge clk) begin
    if (inst_wr_en) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", {27'h0, inst_wr_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", {27'h0, inst_wr_addr}, {27'h0, e.a});
        chk("wr_data", {12'h0, inst_wr_data}, {12'h0, e.d});
      end
    end
  end

  task automatic do_start(input int len);
    start = 1'b1;
    prog_len = (AW+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got;
    repeat (gap) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_in = b;
    got = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (byte_ready) begin got = 1; break; end
    end
    if (!got) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic send_word(input logic [19:0] w, input int gap, inout logic [7:0] cs);
    logic [7:0] b [3];
    b[0] = {4'h0, w[19:16]};
    b[1] = w[15:8];
    b[2] = w[7:0];
    for (int k = 0; k < 3; k++) begin
      send_byte(b[k], gap);
      cs ^= b[k];
    end
  endtask

  // Full load: bytes, optional checksum, FILL, run release, halt -> DONE
  task automatic run_prog(input int len, input int gap, input logic [19:0] w0, input logic [19:0] w1);
    logic [7:0]  cs;
    logic [19:0] w;
    int          n;
    exp_t        e;
    do_start(len);
    cs = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = (i == 0) ? w0 : (i == 1) ? w1 : 20'($urandom);
      e.a = AW'(i);
      e.d = w;
      sb.push_back(e);
      send_word(w, gap, cs);
    end
    if (len < 32) begin
      e.a = AW'(len);
      e.d = 20'hC0000;
      sb.push_back(e);
    end
`ifdef INST_LOADER_CSUM_EN
    send_byte(cs, 0);
`endif
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_run) begin n = k; break; end
    end
`ifdef INST_LOADER_CSUM_EN
    chk("run_latency", n, 2);
`else
    chk("run_latency", n, 3);
`endif
    chk("sb_drained", sb.size(), 0);
    chk("run_busy", {31'h0, busy}, 1);
    @(posedge clk); #1;
    cpu_halted = 1'b1;
    @(posedge clk); #1;
    cpu_halted = 1'b0;
    @(negedge clk);
    chk("done_flags", {29'h0, done, cpu_run, busy}, 32'b110);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] cs;
    exp_t       e;
    // reset state
    #2;
    chk("reset_outs", {byte_ready, inst_wr_en, inst_wr_addr, inst_wr_data, cpu_run, busy, done, error}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // two instructions from the fixed byte stream, then HALT at 2
    run_prog(2, 0, 20'h041C3, 20'h18205);

    // zero length is rejected from DONE, then a clean one-word load
    do_start(0);
    @(negedge clk);
    chk("len0_flags", {28'h0, error, cpu_run, done, busy}, 32'b1000);
    @(posedge clk); #1;
    do_start(33);
    @(negedge clk);
    chk("len33_err", {31'h0, error}, 1);
    @(posedge clk); #1;
    run_prog(1, 0, 20'hABCDE, 20'h0);

    // non-zero B0 high nibble
    do_start(2);
    send_byte(8'h15, 0);
    @(negedge clk);
    chk("nibble_err", {30'h0, error, byte_ready}, 32'b10);
    @(posedge clk); #1;

    // full memory: 32 writes and no HALT fill
    run_prog(32, 0, 20'hFFFFF, 20'h00001);

    // one instruction with a stalling byte stream
    run_prog(1, 1, 20'h35A0F, 20'h0);

    // reset in the middle of a word aborts cleanly
    do_start(3);
    send_byte(8'h02, 0);
    send_byte(8'h77, 0);
    rst = 1'b0;
    #2;
    chk("midreset_outs", {byte_ready, inst_wr_en, inst_wr_addr, inst_wr_data, cpu_run, busy, done, error}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run_prog(3, 0, 20'h2468A, 20'h13579);

`ifdef INST_LOADER_CSUM_EN
    // wrong checksum: the word is written but FILL and run never happen
    do_start(1);
    cs = 8'h00;
    e.a = '0;
    e.d = 20'h9C3E1;
    sb.push_back(e);
    send_word(20'h9C3E1, 0, cs);
    send_byte(cs ^ 8'h5A, 0);
    @(negedge clk);
    chk("csum_bad", {30'h0, error, cpu_run}, 32'b10);
    @(posedge clk); #1;
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_final", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    chk("watchdog", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
